rope_grab_arbiter: RTL and testbench

//  Decides which rope, if any, the monkey is holding. It sits between the rope display

---
 rtl/rope_grab_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_rope_grab_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rope_grab_arbiter.sv
// ============================================================================
// Module   : rope_grab_arbiter
// Brief    : Debounces per-rope monkey collisions into a grab, arbitrates the
//            held rope (lowest index wins), runs release with a cooldown and
//            forwards the held rope's signed speed.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rope_grab_arbiter #(
    parameter int ROPES            = 6,
    parameter int GRAB_FRAMES      = 4,
    parameter int RELEASE_COOLDOWN = 16,
    parameter int SPEED_W          = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       startOfFrame,
    input  logic [ROPES-1:0]           monkeyCollision,
    input  logic                       releaseReq,
    input  logic [ROPES*SPEED_W-1:0]   SIGNED_SPEEDS,
    output logic                       attached,
    output logic [$clog2(ROPES)-1:0]   attachedRope,
    output logic [ROPES-1:0]           ropeMask,
    output logic [SPEED_W-1:0]         ropeSpeed,
    output logic                       grabPulse,
    output logic                       releasePulse
);

    localparam int         c_idx_w = $clog2(ROPES);
    localparam logic [7:0] c_grab  = 8'(GRAB_FRAMES);
    localparam logic [7:0] c_cool  = 8'(RELEASE_COOLDOWN);

    typedef enum logic [1:0] {
        S_FREE = 2'd0,
        S_CAND = 2'd1,
        S_ATT  = 2'd2,
        S_COOL = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_cand;
    logic [7:0]           r_cnt;
    logic [ROPES-1:0]     r_hit_acc;
    logic [ROPES-1:0]     r_frame_hits;
    logic                 r_rel_latch;
    logic                 r_rel_frame;
    logic                 r_tick_d;
    logic                 r_attached;
    logic [ROPES-1:0]     r_mask;
    logic [SPEED_W-1:0]   r_speed;
    logic                 r_grab;
    logic                 r_release;

    state_t               w_state_n;
    logic [c_idx_w-1:0]   w_cand_n;
    logic [c_idx_w-1:0]   w_low;
    logic [7:0]           w_cnt_n;
    logic [7:0]           w_cnt_inc;
    logic                 w_cand_hit;
    logic                 w_drop;
    logic                 w_grab_n;
    logic                 w_release_n;
    logic                 w_att_n;
    logic [SPEED_W-1:0]   w_sel_speed;

    // Lowest-index priority: scanning downward lets the lowest set bit win.
    always_comb begin
        w_low = '0;
        for (int i = ROPES - 1; i >= 0; i--) begin
            if (r_frame_hits[i]) begin
                w_low = i[c_idx_w-1:0];
            end
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_cand_n    = r_cand;
        w_cnt_n     = r_cnt;
        w_grab_n    = 1'b0;
        w_release_n = 1'b0;
        w_cnt_inc   = r_cnt + 8'd1;
        w_cand_hit  = r_frame_hits[r_cand];
        w_drop      = r_rel_frame || !w_cand_hit;

        if (r_tick_d) begin
            case (r_state)
                S_FREE: begin
                    if (|r_frame_hits) begin
                        w_cand_n = w_low;
                        w_cnt_n  = 8'd1;
                        if (GRAB_FRAMES == 1) begin
                            w_state_n = S_ATT;
                            w_grab_n  = 1'b1;
                        end else begin
                            w_state_n = S_CAND;
                        end
                    end
                end
                S_CAND: begin
                    if (w_drop) begin
                        w_state_n = S_FREE;
                    end else begin
                        w_cnt_n = w_cnt_inc;
                        if (w_cnt_inc == c_grab) begin
                            w_state_n = S_ATT;
                            w_grab_n  = 1'b1;
                        end
                    end
                end
                S_ATT: begin
                    if (w_drop) begin
                        w_state_n   = S_COOL;
                        w_release_n = 1'b1;
                        w_cnt_n     = 8'd0;
                    end
                end
                default: begin
                    w_cnt_n = w_cnt_inc;
                    if (w_cnt_inc == c_cool) begin
                        w_state_n = S_FREE;
                    end
                end
            endcase
        end

        w_att_n     = (w_state_n == S_ATT);
        w_sel_speed = '0;
        for (int i = 0; i < ROPES; i++) begin
            if (w_cand_n == i[c_idx_w-1:0]) begin
                w_sel_speed = SIGNED_SPEEDS[i*SPEED_W +: SPEED_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FREE;
            r_cand       <= '0;
            r_cnt        <= '0;
            r_hit_acc    <= '0;
            r_frame_hits <= '0;
            r_rel_latch  <= 1'b0;
            r_rel_frame  <= 1'b0;
            r_tick_d     <= 1'b0;
            r_attached   <= 1'b0;
            r_mask       <= '0;
            r_speed      <= '0;
            r_grab       <= 1'b0;
            r_release    <= 1'b0;
        end else begin
            r_tick_d <= startOfFrame;
            // A hit on the tick cycle itself belongs to the closing frame.
            if (startOfFrame) begin
                r_frame_hits <= r_hit_acc | monkeyCollision;
                r_hit_acc    <= '0;
                r_rel_frame  <= r_rel_latch | releaseReq;
            end else begin
                r_hit_acc <= r_hit_acc | monkeyCollision;
            end

            if (r_tick_d) begin
                r_rel_latch <= releaseReq;
            end else begin
                r_rel_latch <= r_rel_latch | releaseReq;
            end

            r_state    <= w_state_n;
            r_cand     <= w_cand_n;
            r_cnt      <= w_cnt_n;
            r_attached <= w_att_n;
            r_mask     <= w_att_n ? ({{(ROPES-1){1'b0}}, 1'b1} << w_cand_n) : '0;
            r_speed    <= w_att_n ? w_sel_speed : '0;
            r_grab     <= w_grab_n;
            r_release  <= w_release_n;
        end
    end

    assign attached     = r_attached;
    assign attachedRope = r_cand;
    assign ropeMask     = r_mask;
    assign ropeSpeed    = r_speed;
    assign grabPulse    = r_grab;
    assign releasePulse = r_release;

endmodule

`default_nettype wire

// File: tb/tb_rope_grab_arbiter.sv
// ============================================================================
// Module   : tb_rope_grab_arbiter
// Brief    : Directed self-checking bench for rope_grab_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rope_grab_arbiter;

    logic          clk = 1'b0;
    logic          reset;
    logic          startOfFrame;
    logic [5:0]    monkeyCollision;
    logic          releaseReq;
    logic [191:0]  speeds;
    logic          attached;
    logic [2:0]    attachedRope;
    logic [5:0]    ropeMask;
    logic [31:0]   ropeSpeed;
    logic          grabPulse;
    logic          releasePulse;

    int n_chk  = 0;
    int n_pass = 0;

    rope_grab_arbiter #(
        .ROPES(6), .GRAB_FRAMES(4), .RELEASE_COOLDOWN(16), .SPEED_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .startOfFrame(startOfFrame),
        .monkeyCollision(monkeyCollision),
        .releaseReq(releaseReq),
        .SIGNED_SPEEDS(speeds),
        .attached(attached),
        .attachedRope(attachedRope),
        .ropeMask(ropeMask),
        .ropeSpeed(ropeSpeed),
        .grabPulse(grabPulse),
        .releasePulse(releasePulse)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One frame: hits seen mid-frame, then a tick, then the evaluation cycle.
    task automatic frame(input logic [5:0] hits);
        monkeyCollision = hits;
        cyc();
        monkeyCollision = '0;
        cyc();
        startOfFrame = 1'b1;
        cyc();
        startOfFrame = 1'b0;
        cyc();
    endtask

    task automatic tick_only(input logic [5:0] hits);
        startOfFrame    = 1'b1;
        monkeyCollision = hits;
        cyc();
        startOfFrame    = 1'b0;
        monkeyCollision = '0;
        cyc();
    endtask

    task automatic set_speed(input int r, input logic [31:0] v);
        speeds[r*32 +: 32] = v;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk_eq({tag, "_att"},  32'(attached),     32'd0);
        chk_eq({tag, "_rope"}, 32'(attachedRope), 32'd0);
        chk_eq({tag, "_mask"}, 32'(ropeMask),     32'd0);
        chk_eq({tag, "_spd"},  ropeSpeed,         32'd0);
        chk_eq({tag, "_grab"}, 32'(grabPulse),    32'd0);
        chk_eq({tag, "_rel"},  32'(releasePulse), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset           = 1'b1;
        startOfFrame    = 1'b0;
        monkeyCollision = '0;
        releaseReq      = 1'b0;
        speeds          = '0;
        set_speed(1, 32'd7);
        set_speed(2, 32'd25);
        set_speed(3, 32'd100);
        repeat (2) cyc();
        chk_outs_zero("reset");
        reset = 1'b0;
        cyc();

        // Rope 2 for four frames: grab exactly after the fourth.
        for (int f = 0; f < 3; f++) begin
            frame(6'b000100);
            chk_eq("r2_pre_grab", 32'(grabPulse), 32'd0);
            chk_eq("r2_pre_att",  32'(attached),  32'd0);
        end
        frame(6'b000100);
        chk_eq("r2_grab", 32'(grabPulse),    32'd1);
        chk_eq("r2_att",  32'(attached),     32'd1);
        chk_eq("r2_rope", 32'(attachedRope), 32'd2);
        chk_eq("r2_mask", 32'(ropeMask),     32'b000100);
        chk_eq("r2_spd",  ropeSpeed,         32'd25);
        cyc();
        chk_eq("r2_grab_1cyc", 32'(grabPulse), 32'd0);

        // Mid-frame release pulse while the rope is still being hit.
        releaseReq = 1'b1;
        cyc();
        releaseReq = 1'b0;
        frame(6'b000100);
        chk_eq("rel_pulse", 32'(releasePulse), 32'd1);
        chk_eq("rel_att",   32'(attached),     32'd0);
        chk_eq("rel_spd",   ropeSpeed,         32'd0);
        chk_eq("rel_mask",  32'(ropeMask),     32'd0);
        chk_eq("rel_rope",  32'(attachedRope), 32'd2);
        cyc();
        chk_eq("rel_1cyc",  32'(releasePulse), 32'd0);

        // Cooldown: sixteen frames of hits are ignored.
        for (int f = 0; f < 16; f++) begin
            frame(6'b111111);
            chk_eq("cool_grab", 32'(grabPulse),    32'd0);
            chk_eq("cool_rope", 32'(attachedRope), 32'd2);
        end

        // Ropes 1 and 4 together: rope 1 wins.
        frame(6'b010010);
        chk_eq("pri_cand_rope", 32'(attachedRope), 32'd1);
        chk_eq("pri_cand_att",  32'(attached),     32'd0);
        frame(6'b010010);
        frame(6'b010010);
        chk_eq("pri_pre_grab", 32'(grabPulse), 32'd0);
        frame(6'b010010);
        chk_eq("pri_grab", 32'(grabPulse),    32'd1);
        chk_eq("pri_rope", 32'(attachedRope), 32'd1);
        chk_eq("pri_mask", 32'(ropeMask),     32'b000010);
        chk_eq("pri_spd",  ropeSpeed,         32'd7);

        // Losing the held rope releases it.
        frame(6'b000000);
        chk_eq("miss_rel", 32'(releasePulse), 32'd1);
        chk_eq("miss_att", 32'(attached),     32'd0);
        for (int f = 0; f < 16; f++) frame(6'b000000);

        // Rope 3 speed tracking with one cycle of latency.
        for (int f = 0; f < 4; f++) frame(6'b001000);
        chk_eq("r3_att",  32'(attached),     32'd1);
        chk_eq("r3_rope", 32'(attachedRope), 32'd3);
        chk_eq("r3_spd0", ropeSpeed,         32'd100);
        set_speed(3, -32'sd40);
        #1;
        chk_eq("r3_spd_lat", ropeSpeed, 32'd100);
        cyc();
        chk_eq("r3_spd_m40", ropeSpeed, -32'sd40);
        set_speed(3, 32'd60);
        cyc();
        chk_eq("r3_spd_60", ropeSpeed, 32'd60);

        // Reset while attached: everything clears with no release pulse.
        reset = 1'b1;
        cyc();
        chk_outs_zero("midrst");
        reset = 1'b0;
        cyc();

        // Rope 0 for three frames then a gap: no grab.
        for (int f = 0; f < 3; f++) frame(6'b000001);
        frame(6'b000000);
        chk_eq("gap_grab", 32'(grabPulse),    32'd0);
        chk_eq("gap_att",  32'(attached),     32'd0);
        chk_eq("gap_rel",  32'(releasePulse), 32'd0);

        // Collisions present only on the tick cycle still count.
        for (int f = 0; f < 3; f++) tick_only(6'b100000);
        chk_eq("tk_pre_grab", 32'(grabPulse),    32'd0);
        chk_eq("tk_cand",     32'(attachedRope), 32'd5);
        tick_only(6'b100000);
        chk_eq("tk_grab", 32'(grabPulse), 32'd1);
        chk_eq("tk_att",  32'(attached),  32'd1);
        chk_eq("tk_mask", 32'(ropeMask),  32'b100000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
